hs_fifo_sfifo: RTL and testbench



---
 rtl/hs_fifo_sfifo.sv | 219 +++++++++++++++++++++
 tb/tb_hs_fifo_sfifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_fifo_sfifo.sv
// Synchronous FWFT FIFO with optional packet commit and packet drop.
// Define HS_FIFO_SFIFO_SVA_EN to compile in the embedded protocol checker.

package hs_fifo_sfifo_pkg;
    typedef enum logic {BOOL_FALSE = 1'b0, BOOL_TRUE = 1'b1} bool_e;
endpackage

`ifdef HS_FIFO_SFIFO_SVA_EN
module hs_fifo_sfifo_sva #(
    parameter type         DATA_TYPE  = logic [31:0],
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LW         = 5
) (
    input logic          clk,
    input logic          srst,
    input logic          wvalid,
    input DATA_TYPE      wdata,
    input logic          wlast,
    input logic          rvalid,
    input logic          rready,
    input DATA_TYPE      rdata,
    input logic          rlast,
    input logic [LW-1:0] wlevel,
    input logic          pkt_overflow
);
    a_wdata_known: assert property (@(posedge clk) disable iff (srst)
        wvalid |-> !$isunknown({wdata, wlast}));
    a_rdata_known: assert property (@(posedge clk) disable iff (srst)
        rvalid |-> !$isunknown({rdata, rlast}));
    a_rd_stable: assert property (@(posedge clk) disable iff (srst)
        (rvalid && !rready) |=> (rvalid && $stable(rdata) && $stable(rlast)));
    a_wlevel_max: assert property (@(posedge clk) disable iff (srst)
        32'(wlevel) <= FIFO_DEPTH);
    a_pkt_len: assert property (@(posedge clk) disable iff (srst)
        !pkt_overflow);
endmodule
`endif

module hs_fifo_sfifo
    import hs_fifo_sfifo_pkg::*;
#(
    parameter type         DATA_TYPE        = logic [31:0],
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned ALMOST_FULL_LVL  = FIFO_DEPTH,
    parameter int unsigned ALMOST_EMPTY_LVL = 0,
    parameter bool_e       EN_PACKET_MODE   = BOOL_FALSE,
    parameter bool_e       EN_DROP_PACKET   = BOOL_FALSE,
    localparam int unsigned FIFO_LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        wvalid,
    output logic                        wready,
    input  DATA_TYPE                    wdata,
    input  logic                        wlast,
    input  logic                        wdrop,
    output logic                        walmost_full,
    output logic [FIFO_LEVEL_WIDTH-1:0] wlevel,
    output logic                        rvalid,
    input  logic                        rready,
    output DATA_TYPE                    rdata,
    output logic                        rlast,
    output logic                        ralmost_empty,
    output logic [FIFO_LEVEL_WIDTH-1:0] rlevel
);
    localparam int unsigned LW = FIFO_LEVEL_WIDTH;
    localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX  = PW'(2 * FIFO_DEPTH - 1);
    localparam logic [PW-1:0] DEPTH_P  = PW'(FIFO_DEPTH);
    localparam logic [PW:0]   PTR_MOD  = (PW + 1)'(2 * FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic          AF_AT_ZERO = (ALMOST_FULL_LVL == 0) ? 1'b1 : 1'b0;

    // Pointers run modulo 2*FIFO_DEPTH so full and empty stay distinguishable
    // even when the depth is not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PTR_MAX) begin
            nxt = '0;
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    function automatic logic [AW-1:0] ptr_addr(input logic [PW-1:0] ptr);
        logic [PW-1:0] a;
        if (ptr >= DEPTH_P) begin
            a = ptr - DEPTH_P;
        end else begin
            a = ptr;
        end
        return AW'(a);
    endfunction

    function automatic logic [LW-1:0] ptr_diff(input logic [PW-1:0] hi, input logic [PW-1:0] lo);
        logic [PW:0] d;
        if (hi >= lo) begin
            d = {1'b0, hi} - {1'b0, lo};
        end else begin
            d = {1'b0, hi} + PTR_MOD - {1'b0, lo};
        end
        return LW'(d);
    endfunction

    DATA_TYPE      mem_data [FIFO_DEPTH];
    logic          mem_last [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_r, cm_ptr_r, rd_ptr_r;
    logic [PW-1:0] wr_ptr_nxt_s, cm_ptr_nxt_s, rd_ptr_nxt_s;
    logic [LW-1:0] wlevel_r, rlevel_r, wlevel_nxt_s, rlevel_nxt_s;
    logic          wready_r, rvalid_r, walmost_full_r, ralmost_empty_r;
    logic          drop_s, wr_en_s, rd_en_s;

    // Next-pointer and next-level computation
    always_comb begin
        drop_s       = (EN_DROP_PACKET == BOOL_TRUE) && wdrop;
        wr_en_s      = wvalid && wready_r && !drop_s;
        rd_en_s      = rvalid_r && rready;
        wr_ptr_nxt_s = wr_ptr_r;
        cm_ptr_nxt_s = cm_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;

        if (drop_s) begin
            wr_ptr_nxt_s = cm_ptr_r;
        end else if (wr_en_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        // In packet mode only a completed packet becomes visible to the reader
        if (EN_PACKET_MODE == BOOL_TRUE) begin
            if (wr_en_s && wlast) begin
                cm_ptr_nxt_s = ptr_inc(wr_ptr_r);
            end else begin
                cm_ptr_nxt_s = cm_ptr_r;
            end
        end else begin
            cm_ptr_nxt_s = wr_ptr_nxt_s;
        end

        if (rd_en_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        wlevel_nxt_s = ptr_diff(wr_ptr_nxt_s, rd_ptr_nxt_s);
        rlevel_nxt_s = ptr_diff(cm_ptr_nxt_s, rd_ptr_nxt_s);
    end

    // Pointer and status registers
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_r        <= '0;
            cm_ptr_r        <= '0;
            rd_ptr_r        <= '0;
            wlevel_r        <= '0;
            rlevel_r        <= '0;
            wready_r        <= 1'b1;
            rvalid_r        <= 1'b0;
            walmost_full_r  <= AF_AT_ZERO;
            ralmost_empty_r <= 1'b1;
        end else begin
            wr_ptr_r        <= wr_ptr_nxt_s;
            cm_ptr_r        <= cm_ptr_nxt_s;
            rd_ptr_r        <= rd_ptr_nxt_s;
            wlevel_r        <= wlevel_nxt_s;
            rlevel_r        <= rlevel_nxt_s;
            wready_r        <= (wlevel_nxt_s != LVL_FULL);
            rvalid_r        <= (rlevel_nxt_s != '0);
            walmost_full_r  <= (32'(wlevel_nxt_s) >= ALMOST_FULL_LVL);
            ralmost_empty_r <= (32'(rlevel_nxt_s) <= ALMOST_EMPTY_LVL);
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en_s && !srst) begin
            mem_data[ptr_addr(wr_ptr_r)] <= wdata;
            mem_last[ptr_addr(wr_ptr_r)] <= wlast;
        end
    end

    assign wready        = wready_r;
    assign wlevel        = wlevel_r;
    assign walmost_full  = walmost_full_r;
    assign rvalid        = rvalid_r;
    assign rlevel        = rlevel_r;
    assign ralmost_empty = ralmost_empty_r;
    assign rdata         = mem_data[ptr_addr(rd_ptr_r)];
    assign rlast         = rvalid_r && mem_last[ptr_addr(rd_ptr_r)];

`ifdef HS_FIFO_SFIFO_SVA_EN
    logic pkt_overflow_s;
    assign pkt_overflow_s = (EN_PACKET_MODE == BOOL_TRUE) && (wlevel_r == LVL_FULL)
                            && (cm_ptr_r == rd_ptr_r);

    hs_fifo_sfifo_sva #(
        .DATA_TYPE (DATA_TYPE),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LW        (LW)
    ) u_sva (
        .clk         (clk),
        .srst        (srst),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .wlast       (wlast),
        .rvalid      (rvalid_r),
        .rready      (rready),
        .rdata       (rdata),
        .rlast       (rlast),
        .wlevel      (wlevel_r),
        .pkt_overflow(pkt_overflow_s)
    );
`endif
endmodule

// File: tb/tb_hs_fifo_sfifo.sv
// Scoreboard bench for hs_fifo_sfifo: a plain FIFO instance and a
// packet-mode instance with drop enabled, both 4 deep with 8-bit words.
module tb_hs_fifo_sfifo;
    import hs_fifo_sfifo_pkg::*;

    logic clk;
    int   n_cmp = 0;
    int   n_err = 0;

    logic       np_srst, np_wvalid, np_wready, np_wlast, np_wdrop, np_walmost_full;
    logic       np_rvalid, np_rready, np_rlast, np_ralmost_empty;
    logic [7:0] np_wdata, np_rdata;
    logic [2:0] np_wlevel, np_rlevel;

    logic       pk_srst, pk_wvalid, pk_wready, pk_wlast, pk_wdrop, pk_walmost_full;
    logic       pk_rvalid, pk_rready, pk_rlast, pk_ralmost_empty;
    logic [7:0] pk_wdata, pk_rdata;
    logic [2:0] pk_wlevel, pk_rlevel;

    logic [8:0] np_q[$];
    logic [8:0] pk_q[$];
    logic [8:0] pk_pend[$];

    hs_fifo_sfifo #(
        .DATA_TYPE(logic [7:0]), .FIFO_DEPTH(4), .ALMOST_FULL_LVL(3), .ALMOST_EMPTY_LVL(1),
        .EN_PACKET_MODE(BOOL_FALSE), .EN_DROP_PACKET(BOOL_FALSE)
    ) u_np (
        .clk(clk), .srst(np_srst),
        .wvalid(np_wvalid), .wready(np_wready), .wdata(np_wdata), .wlast(np_wlast), .wdrop(np_wdrop),
        .walmost_full(np_walmost_full), .wlevel(np_wlevel),
        .rvalid(np_rvalid), .rready(np_rready), .rdata(np_rdata), .rlast(np_rlast),
        .ralmost_empty(np_ralmost_empty), .rlevel(np_rlevel)
    );

    hs_fifo_sfifo #(
        .DATA_TYPE(logic [7:0]), .FIFO_DEPTH(4),
        .EN_PACKET_MODE(BOOL_TRUE), .EN_DROP_PACKET(BOOL_TRUE)
    ) u_pk (
        .clk(clk), .srst(pk_srst),
        .wvalid(pk_wvalid), .wready(pk_wready), .wdata(pk_wdata), .wlast(pk_wlast), .wdrop(pk_wdrop),
        .walmost_full(pk_walmost_full), .wlevel(pk_wlevel),
        .rvalid(pk_rvalid), .rready(pk_rready), .rdata(pk_rdata), .rlast(pk_rlast),
        .ralmost_empty(pk_ralmost_empty), .rlevel(pk_rlevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Score the handshakes about to happen, advance one clock, then check status.
    task automatic step();
        logic [8:0] e;
        int nw, pw, pr;
        if (np_srst) begin
            np_q.delete();
        end else begin
            if (np_rvalid && np_rready) begin
                if (np_q.size() == 0) begin
                    check_eq("np_underflow", 32'd1, 32'd0);
                end else begin
                    e = np_q.pop_front();
                    check_eq("np_rdata", 32'({np_rdata, np_rlast}), 32'(e));
                end
            end
            if (np_wvalid && np_wready) np_q.push_back({np_wdata, np_wlast});
        end
        if (pk_srst) begin
            pk_q.delete();
            pk_pend.delete();
        end else begin
            if (pk_rvalid && pk_rready) begin
                if (pk_q.size() == 0) begin
                    check_eq("pk_underflow", 32'd1, 32'd0);
                end else begin
                    e = pk_q.pop_front();
                    check_eq("pk_rdata", 32'({pk_rdata, pk_rlast}), 32'(e));
                end
            end
            if (pk_wdrop) begin
                pk_pend.delete();
            end else if (pk_wvalid && pk_wready) begin
                pk_pend.push_back({pk_wdata, pk_wlast});
                if (pk_wlast) begin
                    foreach (pk_pend[i]) pk_q.push_back(pk_pend[i]);
                    pk_pend.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        nw = np_q.size();
        check_eq("np_wlevel", 32'(np_wlevel), 32'(nw));
        check_eq("np_rlevel", 32'(np_rlevel), 32'(nw));
        check_eq("np_wready", 32'(np_wready), (nw != 4) ? 32'd1 : 32'd0);
        check_eq("np_rvalid", 32'(np_rvalid), (nw != 0) ? 32'd1 : 32'd0);
        check_eq("np_walmost_full", 32'(np_walmost_full), (nw >= 3) ? 32'd1 : 32'd0);
        check_eq("np_ralmost_empty", 32'(np_ralmost_empty), (nw <= 1) ? 32'd1 : 32'd0);
        pr = pk_q.size();
        pw = pr + pk_pend.size();
        check_eq("pk_wlevel", 32'(pk_wlevel), 32'(pw));
        check_eq("pk_rlevel", 32'(pk_rlevel), 32'(pr));
        check_eq("pk_wready", 32'(pk_wready), (pw != 4) ? 32'd1 : 32'd0);
        check_eq("pk_rvalid", 32'(pk_rvalid), (pr != 0) ? 32'd1 : 32'd0);
        check_eq("pk_walmost_full", 32'(pk_walmost_full), (pw >= 4) ? 32'd1 : 32'd0);
        check_eq("pk_ralmost_empty", 32'(pk_ralmost_empty), (pr == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic idle();
        np_wvalid = 1'b0; np_wlast = 1'b0; np_wdrop = 1'b0; np_rready = 1'b0;
        pk_wvalid = 1'b0; pk_wlast = 1'b0; pk_wdrop = 1'b0; pk_rready = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        np_rready = 1'b1;
        pk_rready = 1'b1;
        while ((np_rvalid || pk_rvalid) && n < 20) begin
            step();
            n++;
        end
        check_eq("drain_done", 32'(np_rvalid || pk_rvalid), 32'd0);
        np_rready = 1'b0;
        pk_rready = 1'b0;
    endtask

    initial begin
        logic [7:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        np_wdata = 8'h00; pk_wdata = 8'h00;
        idle();
        np_srst = 1'b1; pk_srst = 1'b1;
        step();
        step();
        check_eq("rst_np_wready", 32'(np_wready), 32'd1);
        check_eq("rst_np_rvalid", 32'(np_rvalid), 32'd0);
        check_eq("rst_np_rlast", 32'(np_rlast), 32'd0);
        check_eq("rst_np_ralmost_empty", 32'(np_ralmost_empty), 32'd1);
        check_eq("rst_pk_wready", 32'(pk_wready), 32'd1);
        check_eq("rst_pk_rlast", 32'(pk_rlast), 32'd0);
        np_srst = 1'b0; pk_srst = 1'b0;

        // Fill the plain FIFO with the reader stalled
        for (int i = 0; i < 4; i++) begin
            np_wvalid = 1'b1; np_wdata = seq[i]; np_wlast = (i == 3);
            step();
        end
        np_wvalid = 1'b0; np_wlast = 1'b0;
        check_eq("full_wready", 32'(np_wready), 32'd0);
        check_eq("full_wlevel", 32'(np_wlevel), 32'd4);
        step();
        check_eq("np_hold_rdata", 32'(np_rdata), 32'h11);

        // Read and write together while full: only the read is taken
        np_wvalid = 1'b1; np_wdata = 8'h55; np_rready = 1'b1;
        step();
        np_wvalid = 1'b0;
        check_eq("full_rw_wlevel", 32'(np_wlevel), 32'd3);
        check_eq("full_rw_wready", 32'(np_wready), 32'd1);
        drain();

        // Steady level 1 across pointer wrap
        np_wvalid = 1'b1; np_wdata = 8'h60;
        step();
        for (int i = 0; i < 10; i++) begin
            np_wvalid = 1'b1; np_wdata = 8'(8'h61 + i); np_rready = 1'b1;
            step();
            check_eq("wrap_wlevel", 32'(np_wlevel), 32'd1);
        end
        idle();
        drain();

        // Mixed random traffic on the plain FIFO
        for (int i = 0; i < 60; i++) begin
            np_wvalid = 1'($urandom_range(0, 1));
            np_wdata  = 8'($urandom);
            np_wlast  = 1'($urandom_range(0, 1));
            np_rready = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        drain();

        // Packet becomes readable only after its last word
        pk_wvalid = 1'b1; pk_wdata = 8'hA0; pk_wlast = 1'b0;
        step();
        check_eq("pkt_rvalid_mid", 32'(pk_rvalid), 32'd0);
        pk_wdata = 8'hA1; pk_wlast = 1'b1;
        step();
        idle();
        check_eq("pkt_rvalid_end", 32'(pk_rvalid), 32'd1);
        check_eq("pkt_rlevel", 32'(pk_rlevel), 32'd2);
        drain();

        // Drop discards the open packet and the same-cycle last word
        pk_wvalid = 1'b1; pk_wdata = 8'hB0;
        step();
        pk_wdata = 8'hB1;
        step();
        pk_wdata = 8'hB2; pk_wlast = 1'b1; pk_wdrop = 1'b1;
        step();
        idle();
        check_eq("drop_wlevel", 32'(pk_wlevel), 32'd0);
        pk_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("drop_rvalid", 32'(pk_rvalid), 32'd0);
        end
        idle();

        // Reset in the middle of a packet, then a clean packet afterwards
        pk_wvalid = 1'b1; pk_wdata = 8'hC0;
        step();
        pk_wdata = 8'hC1;
        step();
        idle();
        pk_srst = 1'b1;
        step();
        pk_srst = 1'b0;
        check_eq("mrst_wlevel", 32'(pk_wlevel), 32'd0);
        check_eq("mrst_rvalid", 32'(pk_rvalid), 32'd0);
        check_eq("mrst_ralmost_empty", 32'(pk_ralmost_empty), 32'd1);
        check_eq("mrst_wready", 32'(pk_wready), 32'd1);
        pk_wvalid = 1'b1; pk_wdata = 8'hD0;
        step();
        pk_wdata = 8'hD1; pk_wlast = 1'b1;
        step();
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
